// File: rtl/memlcd_pkg.sv
// Shared definitions for the memory-LCD serial link (transmitter and panel receiver).
package memlcd_pkg;

  // Default panel geometry and link framing.
  localparam int unsigned DEF_WIDTH      = 336;
  localparam int unsigned DEF_HEIGHT     = 536;
  localparam int unsigned DEF_ADDR_BITS  = 10;
  localparam int unsigned DEF_TRAIL_BITS = 16;

  // Header bit positions, in order of arrival on the wire.
  localparam int unsigned HDR_M0       = 0;  // update
  localparam int unsigned HDR_M1       = 1;  // vcom
  localparam int unsigned HDR_M2       = 2;  // all-clear
  localparam int unsigned HDR_ADDR_LSB = 6;

  // Field bit counter width; must cover the longest field (the pixel data).
  localparam int unsigned CNT_BITS = 16;

  // Receiver decode states.
  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StTrail,
    StNext,
    StWait,
    StSkip
  } rx_state_e;

endpackage

// File: rtl/memlcd_sync_edge.sv
// Brings the asynchronous link into the clk domain: 2-flop synchronizers on all three
// lines, rise detection on sclk, rise/fall detection on scs. si is delayed exactly as
// much as sclk, so si_o is the data level at the detected sclk rise.
module memlcd_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic scs_i,
  input  logic si_i,
  output logic sclk_rise_o,
  output logic scs_rise_o,
  output logic scs_fall_o,
  output logic si_o
);

  // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] sclk_q;
  logic [2:0] scs_q;
  logic [1:0] si_q;
  logic       armed_q;

  // Synchronizer chains track the pins even through reset so the level is valid at exit.
  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[1:0], sclk_i};
    scs_q  <= {scs_q[1:0], scs_i};
    si_q   <= {si_q[0], si_i};
  end

  // A frame may only start after scs has been seen low, so leaving reset with scs
  // already high does not start decoding in the middle of a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else if (!scs_q[1]) begin
      armed_q <= 1'b1;
    end
  end

  assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
  assign scs_rise_o  = armed_q & scs_q[1] & ~scs_q[2];
  assign scs_fall_o  = ~scs_q[1] & scs_q[2];
  assign si_o        = si_q[1];

endmodule

// File: rtl/memlcd_panel_rx.sv
// Panel-side receiver for the memory-LCD serial link. Decodes mode header, line address,
// pixel data and trailer from the oversampled link and emits pixel bytes plus events.
module memlcd_panel_rx
  import memlcd_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned HEIGHT     = DEF_HEIGHT,
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
  parameter int unsigned TRAIL_BITS = DEF_TRAIL_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lcd_sclk,
  input  logic                 lcd_si,
  input  logic                 lcd_scs,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_line,
  output logic [5:0]           wr_col,
  output logic [7:0]           wr_data,
  output logic                 line_done,
  output logic                 frame_done,
  output logic                 clear_all,
  output logic                 vcom,
  output logic                 proto_err
);

  localparam int unsigned HDR_BITS = HDR_ADDR_LSB + ADDR_BITS;

  logic sclk_rise;
  logic scs_rise;
  logic scs_fall;
  logic si_s;

  memlcd_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (lcd_sclk),
    .scs_i       (lcd_scs),
    .si_i        (lcd_si),
    .sclk_rise_o (sclk_rise),
    .scs_rise_o  (scs_rise),
    .scs_fall_o  (scs_fall),
    .si_o        (si_s)
  );

  rx_state_e               state_q, state_d;
  logic [CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [HDR_BITS-1:0]     hdr_q, hdr_d;
  logic [7:0]              byte_q, byte_d;
  logic [ADDR_BITS-1:0]    line_q, line_d;
  logic [5:0]              col_q, col_d;
  logic                    from_data_q, from_data_d;  // current TRAIL follows pixel data
  logic                    line_seen_q, line_seen_d;  // completed-line count, saturating at 1
  logic                    vcom_q, vcom_d;

  logic                    wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0]    wr_line_q, wr_line_d;
  logic [5:0]              wr_col_q, wr_col_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic                    line_done_q, line_done_d;
  logic                    frame_done_q, frame_done_d;
  logic                    clear_q, clear_d;
  logic                    err_q, err_d;

  // Fields arrive LSB first, so new bits enter at the top and shift down.
  logic [HDR_BITS-1:0]  hdr_shift;
  logic [7:0]           byte_shift;
  logic [ADDR_BITS-1:0] hdr_addr;
  logic                 hdr_addr_ok;
  logic                 hdr_last;
  logic                 data_last;
  logic                 trail_last;

  assign hdr_shift   = {si_s, hdr_q[HDR_BITS-1:1]};
  assign byte_shift  = {si_s, byte_q[7:1]};
  assign hdr_addr    = hdr_shift[HDR_ADDR_LSB +: ADDR_BITS];
  assign hdr_addr_ok = (hdr_addr != '0) && (32'(hdr_addr) <= HEIGHT);
  assign hdr_last    = (cnt_q == CNT_BITS'(HDR_BITS - 1));
  assign data_last   = (cnt_q == CNT_BITS'(WIDTH - 1));
  assign trail_last  = (cnt_q == CNT_BITS'(TRAIL_BITS - 1));

  // Next-state decode: consume the bit of this cycle first, then apply any scs edge,
  // so an scs fall on the final bit of a field still completes that field.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hdr_d        = hdr_q;
    byte_d       = byte_q;
    line_d       = line_q;
    col_d        = col_q;
    from_data_d  = from_data_q;
    line_seen_d  = line_seen_q;
    vcom_d       = vcom_q;
    wr_valid_d   = 1'b0;
    wr_line_d    = wr_line_q;
    wr_col_d     = wr_col_q;
    wr_data_d    = wr_data_q;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    clear_d      = 1'b0;
    err_d        = 1'b0;

    if (sclk_rise) begin
      cnt_d = cnt_q + CNT_BITS'(1);
      unique case (state_q)
        StHdr, StNext: begin
          hdr_d = hdr_shift;
          if (hdr_last) begin
            cnt_d = '0;
            if (state_q == StHdr) begin
              vcom_d      = hdr_shift[HDR_M1];
              from_data_d = 1'b0;
            end
            // NEXT headers always carry a line address; mode bits are don't-care there.
            if (state_q == StNext || hdr_shift[HDR_M0]) begin
              if (hdr_addr_ok) begin
                state_d = StData;
                line_d  = hdr_addr;
                col_d   = '0;
              end else begin
                err_d   = 1'b1;
                state_d = StSkip;
              end
            end else begin
              clear_d = hdr_shift[HDR_M2];
              state_d = StTrail;
            end
          end
        end
        StData: begin
          byte_d = byte_shift;
          if (cnt_q[2:0] == 3'd7) begin
            wr_valid_d = 1'b1;
            wr_line_d  = line_q;
            wr_col_d   = col_q;
            wr_data_d  = byte_shift;
            col_d      = col_q + 6'd1;
          end
          if (data_last) begin
            cnt_d       = '0;
            from_data_d = 1'b1;
            state_d     = StTrail;
          end
        end
        StTrail: begin
          if (trail_last) begin
            cnt_d = '0;
            if (from_data_q) begin
              line_done_d = 1'b1;
              line_seen_d = 1'b1;
              state_d     = StNext;
            end else begin
              state_d = StWait;
            end
          end
        end
        default: cnt_d = cnt_q;  // IDLE, WAIT, SKIP discard bits
      endcase
    end

    if (scs_fall) begin
      unique case (state_d)
        StNext: begin
          if (cnt_d == '0) begin
            frame_done_d = line_seen_d;
          end else begin
            err_d = 1'b1;
          end
        end
        StHdr, StData, StTrail: err_d = 1'b1;
        default: ;
      endcase
      state_d = StIdle;
      cnt_d   = '0;
    end else if (scs_rise && state_q == StIdle) begin
      state_d     = StHdr;
      cnt_d       = '0;
      line_seen_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hdr_q        <= '0;
      byte_q       <= '0;
      line_q       <= '0;
      col_q        <= '0;
      from_data_q  <= 1'b0;
      line_seen_q  <= 1'b0;
      vcom_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_line_q    <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      clear_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hdr_q        <= hdr_d;
      byte_q       <= byte_d;
      line_q       <= line_d;
      col_q        <= col_d;
      from_data_q  <= from_data_d;
      line_seen_q  <= line_seen_d;
      vcom_q       <= vcom_d;
      wr_valid_q   <= wr_valid_d;
      wr_line_q    <= wr_line_d;
      wr_col_q     <= wr_col_d;
      wr_data_q    <= wr_data_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      clear_q      <= clear_d;
      err_q        <= err_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_line    = wr_line_q;
  assign wr_col     = wr_col_q;
  assign wr_data    = wr_data_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign clear_all  = clear_q;
  assign vcom       = vcom_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_memlcd_panel_rx.sv
// Scoreboard bench for memlcd_panel_rx: a serial transmitter drives the link at
// sclk = clk/4, a frame-level model queues the expected events, and a monitor pops
// and compares whenever the receiver reports anything.
module tb_memlcd_panel_rx;

  localparam int WIDTH      = 336;
  localparam int HEIGHT     = 536;
  localparam int ADDR_BITS  = 10;
  localparam int TRAIL_BITS = 16;
  localparam int BYTES      = WIDTH / 8;
  localparam int HALF_SCLK  = 20;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 lcd_sclk = 1'b0;
  logic                 lcd_si = 1'b0;
  logic                 lcd_scs = 1'b0;
  logic                 wr_valid;
  logic [ADDR_BITS-1:0] wr_line;
  logic [5:0]           wr_col;
  logic [7:0]           wr_data;
  logic                 line_done;
  logic                 frame_done;
  logic                 clear_all;
  logic                 vcom;
  logic                 proto_err;

  memlcd_panel_rx #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_BITS  (ADDR_BITS),
    .TRAIL_BITS (TRAIL_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lcd_sclk   (lcd_sclk),
    .lcd_si     (lcd_si),
    .lcd_scs    (lcd_scs),
    .wr_valid   (wr_valid),
    .wr_line    (wr_line),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .line_done  (line_done),
    .frame_done (frame_done),
    .clear_all  (clear_all),
    .vcom       (vcom),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  typedef enum int {EvWr, EvLine, EvFrame, EvClear, EvErr} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       line;
    int       col;
    int       data;
  } ev_t;

  ev_t exp_q[$];
  bit  tx_bits[$];
  bit  vcom_exp = 1'b0;
  int  assertions = 0;
  int  failures = 0;

  task automatic push_ev(input ev_kind_e kind, input int line, input int col, input int data);
    ev_t e;
    e.kind = kind;
    e.line = line;
    e.col  = col;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    assertions++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_ev(input ev_kind_e kind, input int line, input int col, input int data);
    ev_t e;
    assertions++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event: got kind=%0d line=%0d col=%0d data=%02h, expected no event",
               kind, line, col, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.line != line || e.col != col || e.data != data) begin
        failures++;
        $display("FAIL event: got kind=%0d line=%0d col=%0d data=%02h, expected kind=%0d line=%0d col=%0d data=%02h",
                 kind, line, col, data, e.kind, e.line, e.col, e.data);
      end
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge, report every event present.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wr_valid)   check_ev(EvWr, int'(wr_line), int'(wr_col), int'(wr_data));
      if (line_done)  check_ev(EvLine, 0, 0, 0);
      if (frame_done) check_ev(EvFrame, 0, 0, 0);
      if (clear_all)  check_ev(EvClear, 0, 0, 0);
      if (proto_err)  check_ev(EvErr, 0, 0, 0);
    end
  end

  task automatic push_field(input int value, input int n);
    for (int i = 0; i < n; i++) tx_bits.push_back(value[i]);
  endtask

  task automatic push_hdr(input int m0, input int m1, input int m2, input int addr);
    push_field(m0, 1);
    push_field(m1, 1);
    push_field(m2, 1);
    push_field(0, 3);
    push_field(addr, ADDR_BITS);
  endtask

  task automatic pulse_rst_and_check();
    #100;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_outputs_zero",
              int'({wr_valid, line_done, frame_done, clear_all, vcom, proto_err,
                    wr_line, wr_col, wr_data}), 0);
    @(negedge clk);
    rst = 1'b0;
    vcom_exp = 1'b0;
  endtask

  // Sends tx_bits; cut_at >= 0 either drops scs or pulses rst before that bit.
  task automatic transmit(input int cut_at, input bit cut_is_rst);
    lcd_scs = 1'b1;
    #(2 * HALF_SCLK);
    for (int i = 0; i < tx_bits.size(); i++) begin
      if (i == cut_at) begin
        if (!cut_is_rst) break;
        pulse_rst_and_check();
      end
      lcd_sclk = 1'b0;
      lcd_si   = tx_bits[i];
      #HALF_SCLK;
      lcd_sclk = 1'b1;
      #HALF_SCLK;
    end
    lcd_sclk = 1'b0;
    #HALF_SCLK;
    lcd_scs = 1'b0;
    lcd_si  = 1'b0;
    #(10 * HALF_SCLK);
  endtask

  task automatic finish_frame();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    check_val("events_drained", exp_q.size(), 0);
    exp_q.delete();
    check_val("vcom_level", int'(vcom), int'(vcom_exp));
  endtask

  // Update frame: lines in one scs window. fill < 0 gives random pixel bytes.
  // Expected events are derived from how many bits reach the panel (lim).
  task automatic run_frame(input int lines[$], input bit m1, input int fill,
                           input int cut_at, input bit cut_is_rst);
    int lim;
    bit dead;
    bit done_any;
    int d;
    tx_bits.delete();
    lim      = (cut_at < 0) ? 32'h7fff_ffff : cut_at;
    dead     = 1'b0;
    done_any = 1'b0;
    foreach (lines[i]) begin
      if (i == 0) push_hdr(1, int'(m1), 0, lines[i]);
      else push_hdr(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), lines[i]);
      if (!dead && tx_bits.size() <= lim) begin
        if (i == 0) vcom_exp = m1;
        if (lines[i] < 1 || lines[i] > HEIGHT) begin
          push_ev(EvErr, 0, 0, 0);
          dead = 1'b1;
        end
      end
      for (int j = 0; j < BYTES; j++) begin
        d = (fill < 0) ? int'($urandom_range(0, 255)) : fill;
        push_field(d, 8);
        if (!dead && tx_bits.size() <= lim) push_ev(EvWr, lines[i], j, d);
      end
      push_field(int'($urandom_range(0, 65535)), TRAIL_BITS);
      if (!dead && tx_bits.size() <= lim) begin
        push_ev(EvLine, 0, 0, 0);
        done_any = 1'b1;
      end
    end
    if (!dead) begin
      if (tx_bits.size() <= lim) begin
        if (done_any) push_ev(EvFrame, 0, 0, 0);
      end else if (!cut_is_rst) begin
        push_ev(EvErr, 0, 0, 0);
      end
    end
    transmit(cut_at, cut_is_rst);
    finish_frame();
  endtask

  // Non-update command: header with M0=0 followed by the trailer.
  task automatic run_cmd(input bit m1, input bit m2);
    tx_bits.delete();
    push_hdr(0, int'(m1), int'(m2), int'($urandom_range(0, 1023)));
    push_field(int'($urandom_range(0, 65535)), TRAIL_BITS);
    vcom_exp = m1;
    if (m2) push_ev(EvClear, 0, 0, 0);
    transmit(-1, 1'b0);
    finish_frame();
  endtask

  initial begin
    int lines[$];
    int n;
    repeat (5) @(posedge clk);
    #1;
    check_val("reset_wr_valid", int'(wr_valid), 0);
    check_val("reset_line_done", int'(line_done), 0);
    check_val("reset_frame_done", int'(frame_done), 0);
    check_val("reset_clear_all", int'(clear_all), 0);
    check_val("reset_proto_err", int'(proto_err), 0);
    check_val("reset_vcom", int'(vcom), 0);
    check_val("reset_wr_bus", int'({wr_line, wr_col, wr_data}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    lines = '{1};
    run_frame(lines, 1'($urandom_range(0, 1)), 8'h55, -1, 1'b0);
    lines = '{5, 6, 7};
    run_frame(lines, 1'b0, -1, -1, 1'b0);
    run_cmd(1'b1, 1'b1);
    run_cmd(1'b0, 1'b0);
    lines = '{0};
    run_frame(lines, 1'b1, -1, -1, 1'b0);
    lines = '{537};
    run_frame(lines, 1'b0, -1, -1, 1'b0);
    lines = '{2};
    run_frame(lines, 1'b1, -1, -1, 1'b0);
    lines = '{9};
    run_frame(lines, 1'b1, -1, 16 + 100, 1'b0);
    lines = '{3};
    run_frame(lines, 1'b0, -1, -1, 1'b0);
    lines = '{4, 8};
    run_frame(lines, 1'b1, -1, 16 + 60, 1'b1);
    lines = '{HEIGHT};
    run_frame(lines, 1'b0, -1, -1, 1'b0);
    repeat (3) begin
      lines.delete();
      n = int'($urandom_range(1, 2));
      for (int i = 0; i < n; i++) lines.push_back(int'($urandom_range(1, HEIGHT)));
      run_frame(lines, 1'($urandom_range(0, 1)), -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
